phase_a_result_reducer: RTL and testbench



---
 rtl/phase_a_result_reducer.sv | 119 +++++++++++
 tb/tb_phase_a_result_reducer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_a_result_reducer.sv
// phase_a_result_reducer: buffers phase_a results and applies a word-serial final conditional subtraction r = (a >= m) ? a - m : a.
// Define PHASE_A_RESULT_REDUCER_STATS_EN to add the sub_cnt/drop_cnt statistics outputs.
module phase_a_result_reducer #(
  parameter int N      = 3072,
  parameter int WORD_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_in,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] m,
  output logic [N-1:0] r_out,
  output logic         r_valid,
  input  logic         r_ready,
  output logic         ovf,
  output logic         busy
`ifdef PHASE_A_RESULT_REDUCER_STATS_EN
  ,
  output logic [31:0]  sub_cnt,
  output logic [15:0]  drop_cnt
`endif
);
  localparam int K  = N / WORD_W;
  localparam int CW = K > 1 ? $clog2(K) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]        state;
  logic [N-1:0]      a_reg, m_reg, d_reg, d_next;
  logic [CW-1:0]     cnt;
  logic              borrow;
  logic [N-1:0]      mem [DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [AW:0]       fill;
  logic [WORD_W:0]   diff;
  logic [31:0]       off;
  logic              last, full, push, drop;

  always_comb begin
    off    = WORD_W * 32'(cnt);
    diff   = {1'b0, a_reg[off +: WORD_W]} - {1'b0, m_reg[off +: WORD_W]} - {{WORD_W{1'b0}}, borrow};
    d_next = d_reg;
    d_next[off +: WORD_W] = diff[WORD_W-1:0];
  end

  // The head is popped only when its subtraction completes, so a full buffer can still accept on that edge.
  assign last = state == SUB && cnt == CW'(K - 1);
  assign full = fill == (AW+1)'(DEPTH);
  assign push = en_in && (!full || last);
  assign drop = en_in && full && !last;
  assign busy = state != IDLE || fill != '0;

  always_ff @(posedge clk)
    if (push) mem[wp] <= a_in;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp   <= '0;
      rp   <= '0;
      fill <= '0;
      ovf  <= 1'b0;
    end else begin
      wp   <= push ? wp + 1'b1 : wp;
      rp   <= last ? rp + 1'b1 : rp;
      fill <= fill + (AW+1)'(push) - (AW+1)'(last);
      ovf  <= ovf | drop;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      m_reg   <= '0;
      d_reg   <= '0;
      cnt     <= '0;
      borrow  <= 1'b0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fill != '0) begin
          a_reg  <= mem[rp];
          m_reg  <= m;
          cnt    <= '0;
          borrow <= 1'b0;
          state  <= SUB;
        end
        SUB: begin
          d_reg  <= d_next;
          borrow <= diff[WORD_W];
          cnt    <= cnt + 1'b1;
          if (last) begin
            r_out   <= diff[WORD_W] ? a_reg : d_next;
            r_valid <= 1'b1;
            state   <= OUT;
          end
        end
        OUT: if (r_ready) begin
          r_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

`ifdef PHASE_A_RESULT_REDUCER_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sub_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      sub_cnt  <= sub_cnt + 32'(last && !diff[WORD_W]);
      drop_cnt <= drop && drop_cnt != 16'hFFFF ? drop_cnt + 1'b1 : drop_cnt;
    end
`endif
endmodule

// File: tb/tb_phase_a_result_reducer.sv
// tb_phase_a_result_reducer: randomized and directed checks of the reducer against a plain-arithmetic reference.
module tb_phase_a_result_reducer;
  localparam int N = 256;
  localparam int W = 64;
  localparam int D = 2;
  localparam int K = N / W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en_in = 1'b0;
  logic         r_ready = 1'b0;
  logic [N-1:0] a_in = '0;
  logic [N-1:0] m = '0;
  logic [N-1:0] r_out;
  logic         r_valid, ovf, busy;
  logic [31:0]  sub_cnt;
  logic [15:0]  drop_cnt;
  int checks = 0;
  int failures = 0;

  phase_a_result_reducer #(.N(N), .WORD_W(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .a_in(a_in), .m(m),
    .r_out(r_out), .r_valid(r_valid), .r_ready(r_ready), .ovf(ovf), .busy(busy)
`ifdef PHASE_A_RESULT_REDUCER_STATS_EN
    , .sub_cnt(sub_cnt), .drop_cnt(drop_cnt)
`endif
  );

`ifndef PHASE_A_RESULT_REDUCER_STATS_EN
  assign sub_cnt = '0;
  assign drop_cnt = '0;
`endif

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_red(input logic [N-1:0] a, input logic [N-1:0] mm);
    return (a >= mm) ? a - mm : a;
  endfunction

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; en_in = 1'b0; r_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic strobe(input logic [N-1:0] a);
    a_in = a; en_in = 1'b1;
    tick();
    en_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #1; rst_n = 1'b0; #1;
    checks++;
    if (r_out !== '0 || r_valid !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: r_out=%h r_valid=%b ovf=%b busy=%b, required all zero", r_out, r_valid, ovf, busy);
    end
`ifdef PHASE_A_RESULT_REDUCER_STATS_EN
    checks++;
    if (sub_cnt !== 32'd0 || drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_stats: sub_cnt=%0d drop_cnt=%0d, required 0 0", sub_cnt, drop_cnt);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [N-1:0] a;
    reset_dut();
    r_ready = 1'b1;
    m = ~256'h0 ^ 256'hE;
    a = m + 256'd5;
    strobe(a);
    repeat (K) tick();
    checks++;
    if (r_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: r_valid=%b after %0d edges, required 0", r_valid, K + 1);
    end
    tick();
    checks++;
    if (r_valid !== 1'b1 || r_out !== 256'd5) begin
      failures++;
      $display("FAIL basic_result: r_valid=%b r_out=%h, required 1 and 5", r_valid, r_out);
    end
`ifdef PHASE_A_RESULT_REDUCER_STATS_EN
    checks++;
    if (sub_cnt !== 32'd1) begin
      failures++;
      $display("FAIL basic_sub_cnt: got %0d, required 1", sub_cnt);
    end
`endif
    tick();
    checks++;
    if (r_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_accept: r_valid=%b busy=%b, required 0 0", r_valid, busy);
    end
  endtask

  task automatic test_boundaries();
    logic [N-1:0] as [3];
    logic [N-1:0] ms [3];
    logic [N-1:0] ex [3];
    logic [N-1:0] mb;
    reset_dut();
    r_ready = 1'b1;
    mb = ~256'h0 ^ 256'hE;
    as[0] = mb - 1'b1; ms[0] = mb; ex[0] = mb - 1'b1;
    as[1] = mb;        ms[1] = mb; ex[1] = '0;
    as[2] = ~256'h0;   ms[2] = 256'd1; ex[2] = ~256'h0 - 256'd1;
    for (int j = 0; j < 3; j++) begin
      m = ms[j];
      strobe(as[j]);
      for (int i = 0; i < 4 * K && r_valid !== 1'b1; i++) tick();
      checks++;
      if (r_valid !== 1'b1 || r_out !== ex[j]) begin
        failures++;
        $display("FAIL boundary_%0d: r_valid=%b r_out=%h, required 1 and %h", j, r_valid, r_out, ex[j]);
      end
      tick();
    end
`ifdef PHASE_A_RESULT_REDUCER_STATS_EN
    checks++;
    if (sub_cnt !== 32'd2) begin
      failures++;
      $display("FAIL boundary_sub_cnt: got %0d, required 2", sub_cnt);
    end
`endif
  endtask

  task automatic test_stall();
    logic [N-1:0] a2;
    bit stable;
    reset_dut();
    r_ready = 1'b0;
    m = ~256'h0 ^ 256'hE;
    a2 = m - 256'd3;
    strobe(m + 256'd7);
    repeat (4) tick();
    strobe(a2);
    for (int i = 0; i < 4 * K && r_valid !== 1'b1; i++) tick();
    stable = 1'b1;
    repeat (40) begin
      if (r_valid !== 1'b1 || r_out !== 256'd7) stable = 1'b0;
      tick();
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL stall_hold: r_valid=%b r_out=%h, required 1 and 7 held throughout", r_valid, r_out);
    end
    r_ready = 1'b1;
    tick();
    checks++;
    if (r_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_accept: r_valid=%b, required 0", r_valid);
    end
    repeat (K) tick();
    checks++;
    if (r_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_second_early: r_valid=%b, required 0", r_valid);
    end
    tick();
    checks++;
    if (r_valid !== 1'b1 || r_out !== ref_red(a2, m) || ovf !== 1'b0) begin
      failures++;
      $display("FAIL stall_second: r_valid=%b r_out=%h ovf=%b, required 1 %h 0", r_valid, r_out, ovf, ref_red(a2, m));
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [N-1:0] xs [4];
    reset_dut();
    r_ready = 1'b0;
    m = (rnd() >> 2) | 256'd1;
    for (int j = 0; j < 4; j++) xs[j] = m + (rnd() % m);
    strobe(xs[0]);
    for (int i = 0; i < 4 * K && r_valid !== 1'b1; i++) tick();
    strobe(xs[1]);
    strobe(xs[2]);
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_early: ovf=%b, required 0", ovf);
    end
    strobe(xs[3]);
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: ovf=%b, required 1", ovf);
    end
`ifdef PHASE_A_RESULT_REDUCER_STATS_EN
    checks++;
    if (drop_cnt !== 16'd1) begin
      failures++;
      $display("FAIL drop_cnt: got %0d, required 1", drop_cnt);
    end
`endif
    r_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 4 * K && r_valid !== 1'b1; i++) tick();
      checks++;
      if (r_valid !== 1'b1 || r_out !== ref_red(xs[j], m)) begin
        failures++;
        $display("FAIL ovf_result_%0d: r_valid=%b r_out=%h, required 1 %h", j, r_valid, r_out, ref_red(xs[j], m));
      end
      tick();
    end
    repeat (3 * K) tick();
    checks++;
    if (ovf !== 1'b1 || busy !== 1'b0 || r_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_sticky: ovf=%b busy=%b r_valid=%b, required 1 0 0", ovf, busy, r_valid);
    end
  endtask

  task automatic test_full_pop();
    logic [N-1:0] ys [3];
    reset_dut();
    r_ready = 1'b1;
    m = (rnd() >> 1) | 256'd1;
    for (int j = 0; j < 3; j++) ys[j] = ($urandom_range(0, 1) == 1) ? m + (rnd() % m) : rnd() % m;
    strobe(ys[0]);
    strobe(ys[1]);
    repeat (K - 1) tick();
    strobe(ys[2]);
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_ovf: ovf=%b, required 0", ovf);
    end
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 4 * K && r_valid !== 1'b1; i++) tick();
      checks++;
      if (r_valid !== 1'b1 || r_out !== ref_red(ys[j], m)) begin
        failures++;
        $display("FAIL full_pop_result_%0d: r_valid=%b r_out=%h, required 1 %h", j, r_valid, r_out, ref_red(ys[j], m));
      end
      tick();
    end
`ifdef PHASE_A_RESULT_REDUCER_STATS_EN
    checks++;
    if (drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL full_pop_drop_cnt: got %0d, required 0", drop_cnt);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [N-1:0] z;
    reset_dut();
    r_ready = 1'b1;
    m = (rnd() >> 1) | 256'd1;
    strobe(m + 256'd9);
    for (int i = 0; i < 4 * K && r_valid !== 1'b1; i++) tick();
    tick();
    strobe(m + 256'd11);
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1 || r_out !== 256'd9) begin
      failures++;
      $display("FAIL mid_sub_busy: busy=%b r_out=%h, required 1 and 9", busy, r_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (r_out !== '0 || r_valid !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: r_out=%h r_valid=%b busy=%b ovf=%b, required all zero", r_out, r_valid, busy, ovf);
    end
    #3 rst_n = 1'b1;
    tick();
    z = rnd() % m;
    strobe(z);
    for (int i = 0; i < 4 * K && r_valid !== 1'b1; i++) tick();
    checks++;
    if (r_valid !== 1'b1 || r_out !== ref_red(z, m)) begin
      failures++;
      $display("FAIL after_reset_result: r_valid=%b r_out=%h, required 1 %h", r_valid, r_out, ref_red(z, m));
    end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] a, d;
    bit done;
    reset_dut();
    for (int it = 0; it < 25; it++) begin
      m = (rnd() >> $urandom_range(1, N - 1)) | 256'd1;
      d = rnd() % m;
      a = ($urandom_range(0, 3) == 0) ? m : (($urandom_range(0, 1) == 1) ? m + d : d);
      strobe(a);
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        r_ready = $urandom_range(0, 1);
        if (r_valid === 1'b1 && r_ready) begin
          checks++;
          if (r_out !== ref_red(a, m)) begin
            failures++;
            $display("FAIL random_%0d: r_out=%h, required %h", it, r_out, ref_red(a, m));
          end
          done = 1'b1;
        end
        tick();
      end
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL random_timeout_%0d: r_valid=%b, required 1 within 200 cycles", it, r_valid);
      end
      r_ready = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL random_ovf: ovf=%b, required 0", ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_stall();
    test_full_pop();
    test_overflow();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
